// File: rtl/aes_rnd_pkg.sv
// Shared widths, LFSR constants and FSM states for the DOM AES S-box randomness source.
// Bus widths are functions of share count, blinding coefficient count and bits per coefficient.
package aes_rnd_pkg;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] ZERO_SEED_SUB = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    RND_IDLE,
    RND_LOAD,
    RND_RUN
  } rnd_state_e;

  function automatic int rnd_bus0_w(input int d);
    return 2 * d * (d - 1);
  endfunction

  function automatic int rnd_bus1_w(input int d);
    return d * (d - 1);
  endfunction

  function automatic int rnd_bus2_w(input int d, input int bc, input int bn);
    return 2 * d * (d - 1) + (2 + bc) * bn;
  endfunction

  function automatic int rnd_bus3_w(input int d);
    return 4 * d * (d - 1);
  endfunction

  function automatic int rnd_total_w(input int d, input int bc, input int bn);
    return rnd_bus0_w(d) + rnd_bus1_w(d) + rnd_bus2_w(d, bc, bn) + rnd_bus3_w(d);
  endfunction

  function automatic int rnd_num_lfsr(input int d, input int bc, input int bn);
    return (rnd_total_w(d, bc, bn) + 31) / 32;
  endfunction

endpackage

// File: rtl/lfsr32_step32.sv
// Combinational 32-step advance of a right-shifting Galois LFSR (x^32+x^22+x^2+x+1).
module lfsr32_step32
  import aes_rnd_pkg::*;
(
  input  logic [31:0] state_i,
  output logic [31:0] state_o
);

  logic [31:0] s;

  always_comb begin
    s = state_i;
    for (int i = 0; i < 32; i++) begin
      s = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    end
    state_o = s;
  end

endmodule

// File: rtl/aes_sbox_rnd_src.sv
// Seeded LFSR bank producing the fresh-randomness buses of the DOM AES S-box.
// Define AES_SBOX_RND_ZERO_EN to force all buses to 0 for unmasked debug (never in release).
module aes_sbox_rnd_src
  import aes_rnd_pkg::*;
#(
  parameter int D           = 2,
  parameter int BCOEFF      = 2,
  parameter int BLIND_N_RND = 4,
  localparam int RND_BUS0_W = rnd_bus0_w(D),
  localparam int RND_BUS1_W = rnd_bus1_w(D),
  localparam int RND_BUS2_W = rnd_bus2_w(D, BCOEFF, BLIND_N_RND),
  localparam int RND_BUS3_W = rnd_bus3_w(D)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic [31:0]           seed_word,
  input  logic                  rnd_ready,
  output logic                  rnd_valid,
  output logic [RND_BUS0_W-1:0] rnd_bus0w,
  output logic [RND_BUS1_W-1:0] rnd_bus1w,
  output logic [RND_BUS2_W-1:0] rnd_bus2w,
  output logic [RND_BUS3_W-1:0] rnd_bus3w
);

  localparam int TW = rnd_total_w(D, BCOEFF, BLIND_N_RND);
  localparam int NK = rnd_num_lfsr(D, BCOEFF, BLIND_N_RND);
  localparam int IW = (NK > 1) ? $clog2(NK) : 1;

  rnd_state_e          state_q, state_d;
  logic [NK-1:0][31:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [IW-1:0]       idx_q, idx_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic                seed_ready_q, seed_ready_d;
  logic                seed_fire;
  logic [31:0]         seed_w;

  for (genvar g = 0; g < NK; g++) begin : g_step
    lfsr32_step32 u_step (.state_i(lfsr_q[g]), .state_o(lfsr_nxt[g]));
  end

  assign seed_fire = seed_valid && seed_ready_q;
  // An all-zero Galois state never leaves zero, so substitute a fixed nonzero word.
  assign seed_w    = (seed_word == 32'h0) ? ZERO_SEED_SUB : seed_word;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    idx_d        = idx_q;
    rnd_valid_d  = rnd_valid_q;
    seed_ready_d = 1'b1;
    unique case (state_q)
      RND_IDLE, RND_RUN: begin
        if (seed_fire) begin
          lfsr_d[0] = seed_w;
          if (NK == 1) begin
            state_d     = RND_RUN;
            idx_d       = '0;
            rnd_valid_d = 1'b1;
          end else begin
            state_d     = RND_LOAD;
            idx_d       = IW'(1);
            rnd_valid_d = 1'b0;
          end
        end else if (state_q == RND_RUN && rnd_valid_q && rnd_ready) begin
          lfsr_d = lfsr_nxt;
        end
      end
      RND_LOAD: begin
        if (seed_fire) begin
          lfsr_d[idx_q] = seed_w;
          if (idx_q == IW'(NK - 1)) begin
            state_d     = RND_RUN;
            idx_d       = '0;
            rnd_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = RND_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RND_IDLE;
      lfsr_q       <= '0;
      idx_q        <= '0;
      rnd_valid_q  <= 1'b0;
      seed_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      idx_q        <= idx_d;
      rnd_valid_q  <= rnd_valid_d;
      seed_ready_q <= seed_ready_d;
    end
  end

  assign rnd_valid  = rnd_valid_q;
  assign seed_ready = seed_ready_q;

`ifdef AES_SBOX_RND_ZERO_EN
  assign rnd_bus0w = '0;
  assign rnd_bus1w = '0;
  assign rnd_bus2w = '0;
  assign rnd_bus3w = '0;
`else
  logic [TW-1:0] s;
  assign s = TW'(lfsr_q);
  assign rnd_bus0w = s[RND_BUS0_W-1:0];
  assign rnd_bus1w = s[RND_BUS0_W+RND_BUS1_W-1:RND_BUS0_W];
  assign rnd_bus2w = s[RND_BUS0_W+RND_BUS1_W+RND_BUS2_W-1:RND_BUS0_W+RND_BUS1_W];
  assign rnd_bus3w = s[TW-1:RND_BUS0_W+RND_BUS1_W+RND_BUS2_W];
`endif

endmodule
